// File: rtl/vga_rx_pkg.sv
// Shared constants and types for the VGA receive-side frame decoder.
package vga_rx_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefCols    = 10;
  localparam int unsigned DefRows    = 20;
  localparam int unsigned DefCellW   = 16;
  localparam int unsigned DefCellH   = 16;
  localparam int unsigned DefX0      = 240;
  localparam int unsigned DefY0      = 80;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrLine    = 2'b01;
  localparam logic [1:0] ErrFrame   = 2'b10;
  localparam logic [1:0] ErrBlankVs = 2'b11;

  typedef enum logic [0:0] {
    StSyncWait,
    StFrame
  } rx_state_e;

endpackage

// File: rtl/vga_edge_sync.sv
// Two-stage register of the VGA control inputs with rise/fall strobes.
module vga_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic blank_i,
  input  logic hs_i,
  input  logic vs_i,
  output logic blank_o,
  output logic hs_o,
  output logic vs_o,
  output logic blank_rise_o,
  output logic blank_fall_o,
  output logic hs_rise_o,
  output logic hs_fall_o,
  output logic vs_rise_o,
  output logic vs_fall_o
);

  // Bit order {blank, hs, vs}. VS resets low so reset release never fakes a VS fall.
  logic [2:0] s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 3'b010;
      s2_q <= 3'b010;
    end else begin
      s1_q <= {blank_i, hs_i, vs_i};
      s2_q <= s1_q;
    end
  end

  assign blank_o      = s1_q[2];
  assign hs_o         = s1_q[1];
  assign vs_o         = s1_q[0];
  assign blank_rise_o = s1_q[2] & ~s2_q[2];
  assign blank_fall_o = ~s1_q[2] & s2_q[2];
  assign hs_rise_o    = s1_q[1] & ~s2_q[1];
  assign hs_fall_o    = ~s1_q[1] & s2_q[1];
  assign vs_rise_o    = s1_q[0] & ~s2_q[0];
  assign vs_fall_o    = ~s1_q[0] & s2_q[0];

endmodule

// File: rtl/vga_frame_decoder.sv
// Rebuilds the playfield from a VGA pixel stream and measures line/frame geometry.
module vga_frame_decoder
  import vga_rx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned COLS     = DefCols,
  parameter int unsigned ROWS     = DefRows,
  parameter int unsigned CELL_W   = DefCellW,
  parameter int unsigned CELL_H   = DefCellH,
  parameter int unsigned X0       = DefX0,
  parameter int unsigned Y0       = DefY0,
  localparam int unsigned FW      = COLS * ROWS * 2
) (
  input  logic          iVGA_CLK,
  input  logic          iRST_n,
  input  logic          iBLANK_n,
  input  logic          iHS,
  input  logic          iVS,
  input  logic [7:0]    iB,
  input  logic [7:0]    iG,
  input  logic [7:0]    iR,
  output logic [FW-1:0] oField,
  output logic          oFieldValid,
  output logic [9:0]    oPixCnt,
  output logic [9:0]    oLineCnt,
  output logic [15:0]   oFrameCnt,
  output logic          oErr,
  output logic [1:0]    oErrCode
);

  localparam int unsigned CntW = 12;
  localparam int unsigned IdxW = $clog2(COLS * ROWS);

  logic s1_blank, s1_hs, s1_vs;
  logic blank_rise, blank_fall, hs_rise, hs_fall, vs_rise, vs_fall;

  vga_edge_sync u_edge_sync (
    .clk_i       (iVGA_CLK),
    .rst_ni      (iRST_n),
    .blank_i     (iBLANK_n),
    .hs_i        (iHS),
    .vs_i        (iVS),
    .blank_o     (s1_blank),
    .hs_o        (s1_hs),
    .vs_o        (s1_vs),
    .blank_rise_o(blank_rise),
    .blank_fall_o(blank_fall),
    .hs_rise_o   (hs_rise),
    .hs_fall_o   (hs_fall),
    .vs_rise_o   (vs_rise),
    .vs_fall_o   (vs_fall)
  );

  // Only the MSBs of R and G carry the cell code; blue is ignored.
  logic unused_in;
  assign unused_in = ^{iB, iR[6:0], iG[6:0], s1_hs, hs_rise, hs_fall, blank_rise, vs_rise};

  logic            r7_q, g7_q;
  logic [CntW-1:0] x_q, x_d, y_q, y_d, y_line;
  logic [CntW-1:0] dx, dy;
  logic            samp_hit;
  logic [IdxW-1:0] cell_idx;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic [FW-1:0]   field_q, field_d;
  logic            field_valid_q, field_valid_d;
  logic [9:0]      pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            err_q, err_d, err_hit;
  logic [1:0]      err_code_q, err_code_d, err_new;
  rx_state_e       state_q, state_d;

  // Counters saturate so an endless line cannot wrap back onto a legal length.
  always_comb begin
    x_d = x_q;
    if (blank_fall) begin
      x_d = '0;
    end else if (s1_blank && x_q != '1) begin
      x_d = x_q + CntW'(1);
    end
    y_line = y_q;
    if (blank_fall && y_q != '1) begin
      y_line = y_q + CntW'(1);
    end
    y_d = vs_fall ? '0 : y_line;
  end

  always_comb begin
    dx       = x_q - CntW'(X0);
    dy       = y_q - CntW'(Y0);
    samp_hit = s1_blank && (x_q >= CntW'(X0)) && (y_q >= CntW'(Y0))
            && (dx % CntW'(CELL_W) == CntW'(CELL_W / 2)) && (dx / CntW'(CELL_W) < CntW'(COLS))
            && (dy % CntW'(CELL_H) == CntW'(CELL_H / 2)) && (dy / CntW'(CELL_H) < CntW'(ROWS));
    cell_idx = IdxW'((dy / CntW'(CELL_H)) * CntW'(COLS) + dx / CntW'(CELL_W));
    shadow_d = shadow_q;
    if (samp_hit) begin
      shadow_d[{cell_idx, 1'b0} +: 2] = {r7_q, g7_q};
    end
  end

  always_comb begin
    state_d       = state_q;
    field_d       = field_q;
    field_valid_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    pix_cnt_d     = blank_fall ? x_q[9:0] : pix_cnt_q;
    line_cnt_d    = vs_fall ? y_line[9:0] : line_cnt_q;
    err_hit       = 1'b0;
    err_new       = ErrNone;

    unique case (state_q)
      StSyncWait: begin
        if (vs_fall) begin
          state_d = StFrame;
        end
      end
      StFrame: begin
        if (blank_fall && x_q != CntW'(H_ACTIVE)) begin
          err_hit = 1'b1;
          err_new = ErrLine;
        end else if (vs_fall && y_line != CntW'(V_ACTIVE)) begin
          err_hit = 1'b1;
          err_new = ErrFrame;
        end else if (!s1_vs && s1_blank) begin
          err_hit = 1'b1;
          err_new = ErrBlankVs;
        end
        if (vs_fall) begin
          field_d       = shadow_q;
          field_valid_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 16'd1;
        end
      end
    endcase

    err_d      = err_q | err_hit;
    err_code_d = (!err_q && err_hit) ? err_new : err_code_q;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r7_q          <= 1'b0;
      g7_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      shadow_q      <= '0;
      field_q       <= '0;
      field_valid_q <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ErrNone;
      state_q       <= StSyncWait;
    end else begin
      r7_q          <= iR[7];
      g7_q          <= iG[7];
      x_q           <= x_d;
      y_q           <= y_d;
      shadow_q      <= shadow_d;
      field_q       <= field_d;
      field_valid_q <= field_valid_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      state_q       <= state_d;
    end
  end

  assign oField      = field_q;
  assign oFieldValid = field_valid_q;
  assign oPixCnt     = pix_cnt_q;
  assign oLineCnt    = line_cnt_q;
  assign oFrameCnt   = frame_cnt_q;
  assign oErr        = err_q;
  assign oErrCode    = err_code_q;

endmodule
